// File: rtl/fb_scanout_scheduler.sv
// Framebuffer SRAM arbiter: deadline-driven line prefetch into a ping-pong line
// buffer, rasterizer writes to the back buffer, and end-of-frame front/back swap.
module fb_scanout_scheduler #(
  parameter int LINE_WORDS = 640,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10,
  parameter int DATA_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_start,
  input  logic [ROW_W-1:0]         fetch_row,
  input  logic                     v_de,
  input  logic                     frame_end,
  input  logic                     wr_req,
  input  logic [ROW_W+COL_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic                     swap_req,
  output logic                     swap_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ROW_W+COL_W:0]     mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     lb_we,
  output logic                     lb_bank,
  output logic [COL_W-1:0]         lb_addr,
  output logic [DATA_W-1:0]        lb_data,
  output logic                     underrun
);

  // state | meaning
  // IDLE  | no SRAM access; picks pending fetch first, then a write
  // FETCH | reading one display line into the line buffer bank lb_bank
  // DONE  | line complete; flip line-buffer bank, rewind column
  // WRITE | single rasterizer write to the back buffer, held until mem_ack
  typedef enum logic [1:0] {IDLE, FETCH, DONE, WRITE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

  state_t           state;
  logic             front;
  logic             fetch_pend;
  logic             swap_pend;
  logic [ROW_W-1:0] pend_row;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nx;
  logic             line_req;
  logic             swap_trig;
  logic             swap_now;
  logic             front_nx;

  // Swaps wait out an active line fetch so a line never straddles two buffers.
  always_comb begin
    line_req  = line_start & v_de;
    swap_trig = frame_end & swap_req;
    swap_now  = (state != FETCH) & (swap_trig | swap_pend);
    front_nx  = front ^ swap_now;
    col_nx    = col + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      front      <= 1'b0;
      fetch_pend <= 1'b0;
      swap_pend  <= 1'b0;
      pend_row   <= '0;
      row        <= '0;
      col        <= '0;
      wr_ack     <= 1'b0;
      swap_done  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lb_we      <= 1'b0;
      lb_bank    <= 1'b0;
      lb_addr    <= '0;
      lb_data    <= '0;
      underrun   <= 1'b0;
    end else begin
      lb_we     <= 1'b0;
      wr_ack    <= 1'b0;
      swap_done <= swap_now;
      front     <= front_nx;
      if (swap_now) swap_pend <= 1'b0;
      else if (swap_trig) swap_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (fetch_pend) begin
            state      <= FETCH;
            fetch_pend <= 1'b0;
            row        <= pend_row;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {front_nx, pend_row, {COL_W{1'b0}}};
          end else if (wr_req && !wr_ack && !line_req) begin
            // wr_ack high means the requester has not yet dropped wr_req
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {~front_nx, wr_addr};
            mem_wdata <= wr_data;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            lb_we   <= 1'b1;
            lb_addr <= col;
            lb_data <= mem_rdata;
            if (col == LAST_COL) begin
              state   <= DONE;
              mem_req <= 1'b0;
            end else begin
              col      <= col_nx;
              mem_addr <= {front, row, col_nx};
            end
          end
        end
        DONE: begin
          lb_bank <= ~lb_bank;
          col     <= '0;
          state   <= IDLE;
        end
        WRITE: begin
          if (mem_ack) begin
            wr_ack  <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Later assignment wins: a new line request re-arms the pending flag.
      if (line_req) begin
        fetch_pend <= 1'b1;
        pend_row   <= fetch_row;
        if (state == FETCH) underrun <= 1'b1;
      end
    end
  end

endmodule
